// File: rtl/stopwatch_if.sv
// Stopwatch controller handshake bundle: button/tick events in,
// BCD MM:SS digits and status flags out.
interface stopwatch_if;
  logic       sec_tick;
  logic       adj_tick;
  logic       pause_pulse;
  logic       clr_pulse;
  logic       sw_adj;
  logic       sw_sel;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       adj;
  logic       select;
  logic       running;

  modport master (
    output sec_tick, adj_tick,
    output pause_pulse, clr_pulse,
    output sw_adj, sw_sel,
    input  min_tens, min_ones,
    input  sec_tens, sec_ones,
    input  adj, select, running
  );

  modport slave (
    input  sec_tick, adj_tick,
    input  pause_pulse, clr_pulse,
    input  sw_adj, sw_sel,
    output min_tens, min_ones,
    output sec_tens, sec_ones,
    output adj, select, running
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch controller with PAUSED/RUN/ADJUST states,
// BCD counting and per-field adjust; all outputs registered.
module stopwatch_ctrl #(
  parameter bit ROLL_OVER = 1'b1,
  parameter bit START_RUN = 1'b0
) (
  input logic       clk,
  input logic       rst,
  stopwatch_if.slave sw
);

  typedef enum logic [1:0] {
    ST_PAUSED = 2'd0,
    ST_RUN    = 2'd1,
    ST_ADJUST = 2'd2
  } state_e;

  localparam state_e RST_STATE =
    START_RUN ? ST_RUN : ST_PAUSED;

  state_e     state_q, state_d;
  logic       resume_q, resume_d;
  logic       running_q, running_d;
  logic       adj_q, adj_d;
  logic       sel_q, sel_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;

  logic [7:0] sec_inc;
  logic [7:0] min_inc;
  logic       sec_carry;
  logic       at_max;

  // Two-digit BCD field increment, wrapping 59 -> 00.
  function automatic logic [7:0] inc60(
    input logic [3:0] t,
    input logic [3:0] o
  );
    if (o >= 4'd9) begin
      if (t >= 4'd5) return 8'h00;
      return {t + 4'd1, 4'd0};
    end
    return {t, o + 4'd1};
  endfunction

  assign sec_inc   = inc60(sec_tens_q, sec_ones_q);
  assign min_inc   = inc60(min_tens_q, min_ones_q);
  assign sec_carry = (sec_tens_q == 4'd5) &&
                     (sec_ones_q == 4'd9);
  assign at_max    = sec_carry &&
                     (min_tens_q == 4'd5) &&
                     (min_ones_q == 4'd9);

  always_comb begin
    state_d    = state_q;
    resume_d   = resume_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    adj_d      = sw.sw_adj;
    sel_d      = sw.sw_sel;

    if (sw.clr_pulse) begin
      state_d    = ST_PAUSED;
      resume_d   = 1'b0;
      min_tens_d = 4'd0;
      min_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
    end else if (sw.sw_adj &&
                 state_q != ST_ADJUST) begin
      state_d  = ST_ADJUST;
      resume_d = (state_q == ST_RUN);
    end else if (!sw.sw_adj &&
                 state_q == ST_ADJUST) begin
      state_d = resume_q ? ST_RUN : ST_PAUSED;
    end else if (state_q == ST_ADJUST) begin
      // Field choice uses the registered select, not the live switch.
      if (sw.adj_tick) begin
        if (sel_q) begin
          {sec_tens_d, sec_ones_d} = sec_inc;
        end else begin
          {min_tens_d, min_ones_d} = min_inc;
        end
      end
      if (sw.pause_pulse) resume_d = !resume_q;
    end else begin
      if (state_q == ST_RUN && sw.sec_tick) begin
        if (at_max && !ROLL_OVER) begin
          state_d = ST_PAUSED;
        end else begin
          {sec_tens_d, sec_ones_d} = sec_inc;
          if (sec_carry) begin
            {min_tens_d, min_ones_d} = min_inc;
          end
        end
      end
      if (sw.pause_pulse) begin
        state_d = (state_d == ST_RUN) ?
                  ST_PAUSED : ST_RUN;
      end
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_STATE;
      resume_q   <= 1'b0;
      running_q  <= START_RUN;
      adj_q      <= 1'b0;
      sel_q      <= 1'b0;
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      resume_q   <= resume_d;
      running_q  <= running_d;
      adj_q      <= adj_d;
      sel_q      <= sel_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
    end
  end

  assign sw.min_tens = min_tens_q;
  assign sw.min_ones = min_ones_q;
  assign sw.sec_tens = sec_tens_q;
  assign sw.sec_ones = sec_ones_q;
  assign sw.adj      = adj_q;
  assign sw.select   = sel_q;
  assign sw.running  = running_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random traffic,
// checked against a seconds-count model for ROLL_OVER=1 and =0.
module tb_stopwatch_ctrl;

  localparam int P = 0;
  localparam int R = 1;
  localparam int A = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_sec = 0, s_adjt = 0, s_pau = 0, s_clr = 0;
  logic s_adj = 0, s_sel = 0;

  int errors = 0;
  int checks = 0;

  int m_t[2];
  int m_st[2];
  bit m_res[2];
  bit m_adj[2];
  bit m_sel[2];

  always #5 clk = ~clk;

  stopwatch_if bus1();
  stopwatch_if bus0();

  assign bus1.sec_tick    = s_sec;
  assign bus1.adj_tick    = s_adjt;
  assign bus1.pause_pulse = s_pau;
  assign bus1.clr_pulse   = s_clr;
  assign bus1.sw_adj      = s_adj;
  assign bus1.sw_sel      = s_sel;
  assign bus0.sec_tick    = s_sec;
  assign bus0.adj_tick    = s_adjt;
  assign bus0.pause_pulse = s_pau;
  assign bus0.clr_pulse   = s_clr;
  assign bus0.sw_adj      = s_adj;
  assign bus0.sw_sel      = s_sel;

  stopwatch_ctrl #(
    .ROLL_OVER(1'b1), .START_RUN(1'b0)
  ) dut1 (.clk(clk), .rst(rst), .sw(bus1));

  stopwatch_ctrl #(
    .ROLL_OVER(1'b0), .START_RUN(1'b0)
  ) dut0 (.clk(clk), .rst(rst), .sw(bus0));

  wire [18:0] obs1 = {bus1.min_tens, bus1.min_ones,
                      bus1.sec_tens, bus1.sec_ones,
                      bus1.adj, bus1.select, bus1.running};
  wire [18:0] obs0 = {bus0.min_tens, bus0.min_ones,
                      bus0.sec_tens, bus0.sec_ones,
                      bus0.adj, bus0.select, bus0.running};

  function automatic logic [18:0] mk(
    int mm, int ss, bit a, bit s, bit r
  );
    return {4'(mm / 10), 4'(mm % 10),
            4'(ss / 10), 4'(ss % 10), a, s, r};
  endfunction

  function automatic logic [18:0] expv(int i);
    return mk(m_t[i] / 60, m_t[i] % 60,
              m_adj[i], m_sel[i], m_st[i] == R);
  endfunction

  task automatic check(
    string tag, logic [18:0] o, logic [18:0] e
  );
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, o, e);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_t[i] = 0; m_st[i] = P; m_res[i] = 0;
      m_adj[i] = 0; m_sel[i] = 0;
    end
  endtask

  task automatic model_step(int i, bit ro);
    int mm, ss;
    mm = m_t[i] / 60;
    ss = m_t[i] % 60;
    if (s_clr) begin
      m_t[i] = 0; m_st[i] = P; m_res[i] = 0;
    end else if (s_adj && m_st[i] != A) begin
      m_res[i] = (m_st[i] == R);
      m_st[i] = A;
    end else if (!s_adj && m_st[i] == A) begin
      m_st[i] = m_res[i] ? R : P;
    end else if (m_st[i] == A) begin
      if (s_adjt) begin
        if (m_sel[i]) ss = (ss + 1) % 60;
        else mm = (mm + 1) % 60;
        m_t[i] = mm * 60 + ss;
      end
      if (s_pau) m_res[i] = !m_res[i];
    end else begin
      if (m_st[i] == R && s_sec) begin
        if (m_t[i] == 3599) begin
          if (ro) m_t[i] = 0;
          else m_st[i] = P;
        end else begin
          m_t[i]++;
        end
      end
      if (s_pau) m_st[i] = (m_st[i] == R) ? P : R;
    end
    m_adj[i] = s_adj;
    m_sel[i] = s_sel;
  endtask

  task automatic cyc(bit sec, bit adjt, bit pau, bit clr);
    s_sec = sec; s_adjt = adjt; s_pau = pau; s_clr = clr;
    model_step(1, 1'b1);
    model_step(0, 1'b0);
    @(posedge clk);
    #1;
    s_sec = 0; s_adjt = 0; s_pau = 0; s_clr = 0;
    check("model_ro1", obs1, expv(1));
    check("model_ro0", obs0, expv(0));
  endtask

  task automatic adj_to(int mm, int ss);
    s_adj = 1; s_sel = 0; cyc(0, 0, 0, 0);
    for (int k = 0; k < mm; k++) cyc(0, 1, 0, 0);
    s_sel = 1; cyc(0, 0, 0, 0);
    for (int k = 0; k < ss; k++) cyc(0, 1, 0, 0);
  endtask

  initial begin
    model_reset();
    #12;
    check("reset_ro1", obs1, mk(0, 0, 0, 0, 0));
    check("reset_ro0", obs0, mk(0, 0, 0, 0, 0));
    rst = 0;

    // Start then 61 seconds.
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 61; k++) cyc(1, 0, 0, 0);
    check("count_61", obs1, mk(1, 1, 0, 0, 1));

    // Adjust seconds while running; sec_tick ignored.
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 10; k++) cyc(1, 0, 0, 0);
    check("at_00_10", obs1, mk(0, 10, 0, 0, 1));
    s_adj = 1; s_sel = 1; cyc(0, 0, 0, 0);
    for (int k = 0; k < 55; k++) cyc(1, 1, 0, 0);
    check("adj_sec_wrap", obs1, mk(0, 5, 1, 1, 0));
    s_adj = 0; cyc(0, 0, 0, 0);
    check("adj_resume", obs1, mk(0, 5, 0, 1, 1));

    // 59:58 preload, run over the top.
    cyc(0, 0, 0, 1);
    adj_to(59, 58);
    cyc(0, 0, 1, 0);
    s_adj = 0; cyc(0, 0, 0, 0);
    check("preload", obs1, mk(59, 58, 0, 1, 1));
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("rollover", obs1, mk(0, 0, 0, 1, 1));
    check("hold_max", obs0, mk(59, 59, 0, 1, 0));

    // clear beats pause and tick.
    cyc(0, 0, 0, 1);
    adj_to(12, 34);
    cyc(0, 0, 1, 0);
    s_adj = 0; cyc(0, 0, 0, 0);
    check("at_12_34", obs1, mk(12, 34, 0, 1, 1));
    cyc(1, 0, 1, 1);
    check("clr_prio", obs1, mk(0, 0, 0, 1, 0));

    // tick with pause: tick first, then toggle.
    cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 0);
    check("tick_pause", obs1, mk(0, 1, 0, 1, 0));
    cyc(0, 0, 1, 0);
    check("repause", obs1, mk(0, 1, 0, 1, 1));
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    check("paused_ticks", obs1, mk(0, 2, 0, 1, 1));

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 29) == 0) s_adj = !s_adj;
      if ($urandom_range(0, 9) == 0) s_sel = !s_sel;
      cyc($urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 63) == 0);
    end

    // Async reset mid-adjust.
    s_adj = 0; cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    adj_to(7, 7);
    check("at_07_07", obs1, mk(7, 7, 1, 1, 0));
    #2 rst = 1;
    #1;
    check("async_rst1", obs1, mk(0, 0, 0, 0, 0));
    check("async_rst0", obs0, mk(0, 0, 0, 0, 0));
    model_reset();
    #2 rst = 0;
    cyc(0, 1, 0, 0);
    s_adj = 0; cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    check("post_rst", obs1, mk(0, 0, 0, 1, 0));
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    check("post_rst_run", obs1, mk(0, 1, 0, 1, 1));

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The parameter ROLL_OVER SHALL default to 1 and select the 59:59 behaviour: 1 = wrap to 00:00 and keep running; 0 = hold 59:59 and enter PAUSED.
REQ-002 The parameter START_RUN SHALL default to 0 and set the post-reset state: 0 = PAUSED, 1 = RUN.
REQ-003 The module SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-004 Port clk: input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-005 Port rst: input, 1 bit, asynchronous active-high reset.
REQ-006 Port sec_tick: input, 1 bit, single-cycle 1 Hz count enable.
REQ-007 Port adj_tick: input, 1 bit, single-cycle 2 Hz adjust enable.
REQ-008 Port pause_pulse: input, 1 bit, single-cycle debounced pause-button event.
REQ-009 Port clr_pulse: input, 1 bit, single-cycle debounced clear-button event.
REQ-010 Port sw_adj: input, 1 bit, adjust-mode switch, level-sensitive.
REQ-011 Port sw_sel: input, 1 bit, field select during adjust: 0 = minutes, 1 = seconds.
REQ-012 Ports min_tens, min_ones, sec_tens, sec_ones: outputs, 4 bits each, BCD digits of MM:SS.
REQ-013 Ports adj and select: outputs, 1 bit each, registered copies of sw_adj and sw_sel for the display blink logic.
REQ-014 Port running: output, 1 bit, high while the controller is in RUN.

Function
REQ-015 The controller SHALL have three states: PAUSED, RUN, ADJUST; the state register is 2 bits and the encoding is free.
REQ-016 Every output SHALL be registered; the effect of an input event SHALL be visible on the outputs exactly one clk cycle after the event cycle.
REQ-017 Priority SHALL be: clr_pulse, then ADJUST entry/exit, then pause_pulse, then ticks.
REQ-018 clr_pulse SHALL set all digits to 0 and the state to PAUSED, in any state, overriding a same-cycle tick or pause.
REQ-019 When sw_adj=1 outside ADJUST: enter ADJUST and save resume = (state==RUN).
REQ-020 When sw_adj=0 in ADJUST: go to RUN if resume=1, otherwise to PAUSED.
REQ-021 pause_pulse SHALL toggle RUN<->PAUSED; in ADJUST it SHALL toggle resume instead.
REQ-022 In RUN, sec_tick SHALL increment MM:SS by one second with BCD carry:
- sec_ones 9->0 carries into sec_tens;
- sec_tens 5->0 carries into min_ones;
- min_ones 9->0 carries into min_tens.
REQ-023 At 59:59 in RUN, sec_tick SHALL give 00:00 and stay in RUN when ROLL_OVER=1, or hold 59:59 and enter PAUSED when ROLL_OVER=0.
REQ-024 A same-cycle pause_pulse and sec_tick SHALL apply the tick according to the pre-edge state, then toggle.
REQ-025 In ADJUST, sec_tick SHALL be ignored; adj_tick SHALL increment the selected field modulo 60 (59->00) with no carry into the other field.
REQ-026 In ADJUST, the unselected field SHALL hold its value.
REQ-027 A sw_sel change in ADJUST SHALL affect the next adj_tick only; a same-cycle sw_sel change and adj_tick SHALL use the pre-edge select register.
REQ-028 In PAUSED, both ticks SHALL be ignored.
REQ-029 running SHALL be 1 only in RUN.
REQ-030 adj and select SHALL follow sw_adj and sw_sel with one cycle of latency.
REQ-031 Digits SHALL never hold a non-BCD value or exceed 59:59.

Reset
REQ-032 Asserting rst SHALL immediately, without a clock edge, force:
- all digits to 0;
- adj=0, select=0, resume=0;
- state to PAUSED, or RUN when START_RUN=1;
- running to match that state.
REQ-033 rst asserted mid-count or mid-adjust SHALL discard all pending events; deasserting rst SHALL resume normal operation on the first subsequent rising clk edge.

Verification
REQ-034 Reset then pause_pulse, then 61 sec_ticks -> running=1 and digits read 01:01.
REQ-035 Preload to 59:58 via ADJUST, exit ADJUST into RUN, then 2 sec_ticks -> 00:00 with running=1 (ROLL_OVER=1); with ROLL_OVER=0 -> 59:59 and running=0.
REQ-036 In RUN at 00:10, assert sw_adj=1 and sw_sel=1, apply 55 adj_ticks plus sec_ticks -> 00:05, minutes unchanged; deassert sw_adj -> RUN resumes (resume=1).
REQ-037 clr_pulse, pause_pulse and sec_tick all in one cycle while at 12:34 in RUN -> next cycle 00:00 with running=0.
REQ-038 pause_pulse with sec_tick in one cycle while in RUN at 00:00 -> 00:01 with running=0; a second pause_pulse -> running=1.
REQ-039 Assert rst asynchronously mid-cycle at 07:07 in ADJUST -> outputs return to reset values before the next clk edge.
